// File: rtl/replica_exchange_judge.sv
// Per-replica Metropolis exchange judge: sequential shift-add multiply of dBeta*dE, then threshold test.
// Optional REPLICA_EXCHANGE_STAT_EN adds a saturating accept counter output (accept_count).
package replica_pkg;
    typedef enum logic [1:0] {
        OPT_OR0  = 2'd0,
        OPT_OR1  = 2'd1,
        OPT_THR  = 2'd2,
        OPT_HOLD = 2'd3
    } opt_command_t;
endpackage

module replica_exchange_judge
    import replica_pkg::*;
#(
    parameter int id          = 0,
    parameter int replica_num = 32,
    parameter int energy_w    = 24,
    parameter int beta_w      = 16,
    parameter int frac_shift  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  opt_command_t        opt_command,
    input  logic [energy_w-1:0] energy_self,
    input  logic [energy_w-1:0] energy_folw,
    input  logic [beta_w-1:0]   beta_self,
    input  logic [beta_w-1:0]   beta_folw,
    input  logic [31:0]         r_exchange,
    output logic                busy,
    output logic                done,
`ifdef REPLICA_EXCHANGE_STAT_EN
    output logic [31:0]         accept_count,
`endif
    output logic                exchange_flag
);
    localparam int PW = energy_w + beta_w + 1;
    localparam int SW = ((PW > 33) ? PW : 33) + 1;
    localparam int CW = $clog2(beta_w + 1);
    localparam logic ID_ODD   = ((id % 2) == 1);
    localparam logic IN_RANGE = (id < replica_num - 1);

    typedef enum logic [2:0] {S_IDLE, S_SKIP, S_MUL, S_SIGN, S_JUDGE} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [beta_w-1:0]      mplier_q;
    logic signed [PW-1:0]   mcand_q;
    logic signed [PW-1:0]   acc_q;
    logic                   neg_q;
    logic [31:0]            r_q;
    logic                   busy_q, done_q, flag_q;

    logic                   active;
    logic signed [energy_w:0] de;
    logic [beta_w-1:0]      db;
    logic signed [PW-1:0]   p;
    logic signed [SW-1:0]   sum;
    logic                   accept;

    always_comb begin
        active = 1'b0;
        case (opt_command)
            OPT_OR1: active = ID_ODD && IN_RANGE;
            OPT_THR: active = 1'b0;
            default: active = !ID_ODD && IN_RANGE;
        endcase
    end

    // Multiplier carries |dBeta|; its sign is folded back in after the last partial product.
    assign de = $signed({1'b0, energy_self}) - $signed({1'b0, energy_folw});
    assign db = (beta_self >= beta_folw) ? (beta_self - beta_folw) : (beta_folw - beta_self);

    assign p      = acc_q >>> frac_shift;
    assign sum    = {{(SW-PW){p[PW-1]}}, p} + {{(SW-32){1'b0}}, r_q};
    assign accept = (sum >= 0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            r_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (active) begin
                            state_q  <= S_MUL;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            mplier_q <= db;
                            mcand_q  <= {{(PW-energy_w-1){de[energy_w]}}, de};
                            acc_q    <= '0;
                            neg_q    <= (beta_self < beta_folw);
                            r_q      <= r_exchange;
                        end else begin
                            state_q <= S_SKIP;
                        end
                    end
                end
                S_SKIP: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                    flag_q  <= 1'b0;
                end
                S_MUL: begin
                    if (mplier_q[0])
                        acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q <<< 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(beta_w - 1))
                        state_q <= S_SIGN;
                end
                S_SIGN: begin
                    if (neg_q)
                        acc_q <= -acc_q;
                    state_q <= S_JUDGE;
                end
                S_JUDGE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    flag_q  <= accept;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign exchange_flag = flag_q;

`ifdef REPLICA_EXCHANGE_STAT_EN
    logic [31:0] acc_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            acc_cnt_q <= '0;
        else if (state_q == S_JUDGE && accept && acc_cnt_q != 32'hFFFF_FFFF)
            acc_cnt_q <= acc_cnt_q + 32'd1;
    end

    assign accept_count = acc_cnt_q;
`endif
endmodule
